// File: rtl/md_seq_pkg.sv
// Shared encodings and latency lookup for the Execute-stage multiply/divide sequencer.
package md_seq_pkg;

    localparam logic [2:0] WAY_MULT  = 3'd0;
    localparam logic [2:0] WAY_MULTU = 3'd1;
    localparam logic [2:0] WAY_DIV   = 3'd2;
    localparam logic [2:0] WAY_DIVU  = 3'd3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic way_legal(input logic [2:0] way);
        return (way[2] == 1'b0);
    endfunction

    function automatic int unsigned lat_of_way(input logic [2:0]   way,
                                               input int unsigned mult_lat,
                                               input int unsigned div_lat);
        return ((way == WAY_MULT) || (way == WAY_MULTU)) ? mult_lat : div_lat;
    endfunction

endpackage

// File: rtl/md_seq_if.sv
// Request/strobe bundle between the E-stage controller (master) and the MD sequencer (slave).
interface md_seq_if;

    logic       start;
    logic [2:0] way;
    logic       div_zero;
    logic       HIw;
    logic       LOw;
    logic       d_md_use;
    logic       busy;
    logic       d_stall;
    logic       opnd_le;
    logic [2:0] op_q;
    logic       res_we;
    logic       hi_we_mt;
    logic       lo_we_mt;
    logic       err;

    modport master (
        output start, way, div_zero, HIw, LOw, d_md_use,
        input  busy, d_stall, opnd_le, op_q, res_we, hi_we_mt, lo_we_mt, err
    );

    modport slave (
        input  start, way, div_zero, HIw, LOw, d_md_use,
        output busy, d_stall, opnd_le, op_q, res_we, hi_we_mt, lo_we_mt, err
    );

endinterface

// File: rtl/md_seq.sv
// Multiply/divide sequencer: accepts ops, counts latency, strobes operand latch,
// HI/LO commit and mthi/mtlo writes, and raises the D-stage stall.
module md_seq
    import md_seq_pkg::*;
#(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input logic     clk,
    input logic     reset,
    md_seq_if.slave md
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic             busy;
    logic             accept;

    assign busy   = (state_q == RUN);
    assign accept = md.start & ~busy & way_legal(md.way) & ~reset;

    assign md.busy     = busy;
    assign md.d_stall  = md.d_md_use & (busy | md.start);
    assign md.opnd_le  = accept;
    assign md.op_q     = op_q;
    assign md.res_we   = busy & (cnt_q == '0) & ~zero_q;
    assign md.hi_we_mt = md.HIw & ~busy & ~reset;
    assign md.lo_we_mt = md.LOw & ~busy & ~reset;
    assign md.err      = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        zero_d  = zero_q;
        err_d   = err_q;
        if (busy) begin
            if (md.start | md.HIw | md.LOw) err_d = 1'b1;
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
        end else if (md.start) begin
            if (accept) begin
                state_d = RUN;
                op_d    = md.way;
                zero_d  = md.div_zero & md.way[1];
                // Load LAT-1 so that the zero-count cycle is the LAT-th busy cycle.
                cnt_d   = CNT_W'(lat_of_way(md.way, MULT_LAT, DIV_LAT) - 1);
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_md_seq.sv
// Scoreboard bench for md_seq: expected commits are queued at accept and popped on res_we.
module tb_md_seq;
    import md_seq_pkg::*;

    localparam int unsigned ML = 5;
    localparam int unsigned DL = 10;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic reset;

    md_seq_if bus ();

    md_seq #(.MULT_LAT(ML), .DIV_LAT(DL), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] op;
    } commit_t;

    commit_t    sb[$];
    int         total = 0;
    int         bad   = 0;
    int         t     = 0;
    int         m_acc = -100;
    int         m_lat = 0;
    bit         m_run = 1'b0;
    bit         m_err = 1'b0;
    logic [2:0] m_op  = 3'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    // One bench cycle: drive inputs after the edge, check mid-cycle, then advance the model.
    task automatic cyc(input bit st, input logic [2:0] w, input bit dz,
                       input bit hw, input bit lw, input bit use_, input bit rst);
        bit      eb;
        bit      acc;
        bit      exp_rw;
        commit_t c;
        @(posedge clk);
        #1;
        reset        = rst;
        bus.start    = st;
        bus.way      = w;
        bus.div_zero = dz;
        bus.HIw      = hw;
        bus.LOw      = lw;
        bus.d_md_use = use_;
        eb  = m_run && (t > m_acc) && (t <= m_acc + m_lat);
        acc = st && !eb && (w < 3'd4) && !rst;
        @(negedge clk);
        check_eq("busy",     32'(bus.busy),     32'(eb));
        check_eq("d_stall",  32'(bus.d_stall),  32'(use_ && (eb || st)));
        check_eq("opnd_le",  32'(bus.opnd_le),  32'(acc));
        check_eq("hi_we_mt", 32'(bus.hi_we_mt), 32'(hw && !eb && !rst));
        check_eq("lo_we_mt", 32'(bus.lo_we_mt), 32'(lw && !eb && !rst));
        check_eq("err",      32'(bus.err),      32'(m_err));
        check_eq("op_q",     32'(bus.op_q),     32'(m_op));
        exp_rw = (sb.size() > 0) && (sb[0].cyc == t);
        check_eq("res_we",   32'(bus.res_we),   32'(exp_rw));
        if (exp_rw) begin
            c = sb.pop_front();
            check_eq("commit_op", 32'(bus.op_q), 32'(c.op));
        end
        if (rst) begin
            m_run = 1'b0;
            m_acc = -100;
            m_op  = 3'd0;
            m_err = 1'b0;
            sb.delete();
        end else begin
            if (st && (eb || w >= 3'd4)) m_err = 1'b1;
            if ((hw || lw) && eb)        m_err = 1'b1;
            if (acc) begin
                m_run = 1'b1;
                m_acc = t;
                m_lat = (w < 3'd2) ? int'(ML) : int'(DL);
                m_op  = w;
                if (!(dz && w[1])) begin
                    c.cyc = t + m_lat;
                    c.op  = w;
                    sb.push_back(c);
                end
            end
        end
        t++;
    endtask

    task automatic idle(input int n, input bit use_);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, use_, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.way      = 3'd0;
        bus.div_zero = 1'b0;
        bus.HIw      = 1'b0;
        bus.LOw      = 1'b0;
        bus.d_md_use = 1'b0;

        do_reset();
        idle(2, 1'b0);

        // mult with D-stage MD instruction waiting behind it
        cyc(1'b1, WAY_MULT, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(7, 1'b1);

        // divu normal, then div by zero
        cyc(1'b1, WAY_DIVU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(11, 1'b0);
        cyc(1'b1, WAY_DIV, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(12, 1'b0);

        // start while running is ignored and flags err
        cyc(1'b1, WAY_MULT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        cyc(1'b1, WAY_MULTU, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b0);
        do_reset();

        // mthi during run, then mthi/mtlo in idle, then mtlo alongside an accepted start
        cyc(1'b1, WAY_MULTU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        cyc(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        do_reset();
        cyc(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, WAY_DIV, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(11, 1'b0);

        // illegal way
        cyc(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        do_reset();

        // reset mid-run discards the op; a later mult proceeds normally
        cyc(1'b1, WAY_DIV, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        do_reset();
        idle(1, 1'b0);
        cyc(1'b1, WAY_MULT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(7, 1'b0);

        // back-to-back: next start in the first non-busy cycle
        cyc(1'b1, WAY_MULT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(5, 1'b0);
        cyc(1'b1, WAY_DIV, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(11, 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(3) == 0),
                3'($urandom_range(5)),
                1'($urandom_range(1)),
                ($urandom_range(7) == 0),
                ($urandom_range(7) == 0),
                1'($urandom_range(1)),
                ($urandom_range(63) == 0));
        end

        idle(20, 1'b0);
        check_eq("sb_drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_seq.md
Name: md_seq

Overview:
- Sequencer for the Execute-stage multiply/divide unit.
- Accepts start/way/mthi/mtlo requests from the E-stage controller and runs the latency counter.
- Latches the operation and strobes operand capture and HI/LO result commit.
- Generates the D-stage stall when an MD-class instruction meets a busy or starting unit. The MD datapath (product/quotient, HI/LO registers) is driven by this block's strobes.

Parameters:
- MULT_LAT, 5, cycles busy for mult/multu; legal range 1..2^CNT_W-1.
- DIV_LAT, 10, cycles busy for div/divu; legal range 1..2^CNT_W-1.
- CNT_W, 4, latency counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  E-stage instr is mult/multu/div/divu (one-cycle request)
- way  in  3  op select, valid with start: 0 mult, 1 multu, 2 div, 3 divu, others illegal
- div_zero  in  1  divisor operand == 0, valid with start
- HIw  in  1  E-stage mthi
- LOw  in  1  E-stage mtlo
- d_md_use  in  1  D-stage instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  out  1  unit occupied
- d_stall  out  1  freeze F/D, bubble into E
- opnd_le  out  1  datapath operand/op latch enable
- op_q  out  3  latched way of the running op
- res_we  out  1  commit pending result to HI and LO
- hi_we_mt  out  1  write HI from rs (mthi)
- lo_we_mt  out  1  write LO from rs (mtlo)
- err  out  1  sticky protocol-violation flag

Behaviour:
- Reset: all outputs 0 in the cycle after reset is sampled high. State IDLE, cnt=0, op_q=0, zero_q=0, err=0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1. cnt counts down.
- Accept condition: start=1 in IDLE with a legal way (0..3) at cycle t.
  - opnd_le=1 in cycle t (combinational).
  - Edge ending t: op_q<=way, zero_q<=div_zero & way[1], cnt<=LAT-1 (LAT=MULT_LAT for way 0/1, DIV_LAT for 2/3), state<=RUN.
- RUN: cnt decrements each cycle. When cnt==0: res_we=!zero_q (registered-state combinational), state<=IDLE.
  - Net timing: busy high cycles t+1..t+LAT. res_we in cycle t+LAT. HI/LO visible from t+LAT+1. busy low at t+LAT+1.
- Divide by zero: full DIV_LAT busy interval, res_we suppressed, HI/LO unchanged.
- start with illegal way (4..7): ignored, err<=1, stays IDLE, opnd_le=0.
- start while RUN: ignored (no restart, no relatch), err<=1. The pipeline prevents this via d_stall.
- hi_we_mt = HIw & !busy; lo_we_mt = LOw & !busy.
  - HIw/LOw while busy: write suppressed, err<=1.
  - HIw and LOw together: both strobes, no error.
- HIw/LOw coincident with an accepted start: mt strobe still issued (the op reads rs/rt, not HI/LO). The result commit later overwrites.
- d_stall = d_md_use & (busy | start). Purely combinational, no register on the path.
- Back-to-back: a start in cycle t+LAT+1 (first non-busy cycle) is accepted normally. res_we of the previous op already fired in t+LAT.
- LAT=1: RUN lasts one cycle. busy and res_we are both high in t+1.
- err clears only on reset.
- Reset mid-RUN: returns to IDLE next cycle. No res_we, no mt strobes, pending op discarded.

Decomposition:
- Shared package holds:
  - way encodings: WAY_MULT=0, WAY_MULTU=1, WAY_DIV=2, WAY_DIVU=3.
  - state encoding: IDLE=0, RUN=1.
  - a latency-lookup function of way.
- No sub-module needed. Optional md_lat_cnt (load/decrement/zero flag) if reused by a future pipelined multiplier.

Test Plan:
- mult (way=0) at t=10, d_md_use=1 from t=10 -> opnd_le@10; busy 11..15; res_we@15 only; d_stall 10..15, low @16.
- divu (way=3), div_zero=0 at t=5 -> busy 6..15, res_we@15; with div_zero=1 and way=2 -> busy 6..15, res_we never asserted.
- mult accepted t=0; second start at t=3 -> ignored, err=1 @4, res_we still @5 with op_q=0.
- HIw=1 at t=2 during RUN -> hi_we_mt=0, err=1; HIw=1 in IDLE -> hi_we_mt=1 same cycle, err unchanged.
- div accepted t=0, reset at t=4 -> busy=0 and state IDLE @5; no res_we through t=12; new mult at t=6 accepted, res_we@11.
- Back-to-back: mult at t=0, div at t=6 -> res_we@5 and @16; busy continuous 1..5 and 7..16, low @6.
